// File: rtl/data_mem_hs_if.sv
// Request/response handshake bundle between the LSU (master) and data_mem_hs (slave).
// Request and response channels are each guarded by their own valid/ready pair.
interface data_mem_hs_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int NB = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [NB-1:0]     req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_hs.sv
// Byte-addressable data memory with valid/ready request and response; DATA_MEM_CHECK_EN adds alignment/range errors.
// Latency: rsp_valid rises LATENCY cycles after the accept cycle; one access in flight at a time.
// Backpressure: req_ready only in IDLE; the response is held stable until rsp_valid & rsp_ready.
module data_mem_hs #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 512,
    parameter int LATENCY   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    data_mem_hs_if.slave           bus,
    input  logic                   init_en,
    input  logic [MEM_BYTES*8-1:0] init_data
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = $clog2(MEM_BYTES);
    localparam int CNT_W = $clog2(LATENCY + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NB-1:0]     be_q, be_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [7:0]        mem_q [MEM_BYTES];
    logic [7:0]        mem_d [MEM_BYTES];

    logic              accept;
    logic              commit;
    logic              c_we;
    logic              c_err;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [NB-1:0]     c_be;
    logic [IDX_W-1:0]  lane_idx [NB];
    logic [DATA_W-1:0] lane_rdata;

    assign accept = (state_q == ST_IDLE) && bus.req_valid;

    // With single-cycle latency the access commits on the accept edge, straight from the request bus.
    always_comb begin
        if (LATENCY == 1) begin
            commit  = accept;
            c_we    = bus.req_we;
            c_addr  = bus.req_addr;
            c_wdata = bus.req_wdata;
            c_be    = bus.req_be;
        end else begin
            commit  = (state_q == ST_WAIT) && (cnt_q == CNT_W'(1));
            c_we    = we_q;
            c_addr  = addr_q;
            c_wdata = wdata_q;
            c_be    = be_q;
        end
    end

`ifdef DATA_MEM_CHECK_EN
    assign c_err = ((c_addr & ADDR_W'(NB - 1)) != '0) || ((c_addr >> IDX_W) != '0);
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^c_addr[ADDR_W-1:IDX_W];
    assign c_err          = 1'b0;
`endif

    always_comb begin
        lane_rdata = '0;
        for (int k = 0; k < NB; k++) begin
            lane_idx[k]           = c_addr[IDX_W-1:0] + IDX_W'(k);
            lane_rdata[8*k +: 8]  = mem_q[lane_idx[k]];
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (commit && c_we && !c_err) begin
            for (int k = 0; k < NB; k++) begin
                if (c_be[k]) begin
                    mem_d[lane_idx[k]] = c_wdata[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    be_d    = bus.req_be;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (commit) begin
            rdata_d = (c_we || c_err) ? '0 : lane_rdata;
            err_d   = c_err;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem_q[i] <= init_en ? init_data[8*i +: 8] : 8'h00;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            mem_q   <= mem_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_data_mem_hs.sv
// Randomised bench for data_mem_hs (LATENCY=3) against a byte-array memory model.
// Checks handshake timing, byte strobes, address wrap/errors and reset preload.
module tb_data_mem_hs;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MEM_BYTES = 512;
    localparam int LATENCY   = 3;
    localparam int NB        = DATA_W / 8;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   init_en = 1'b0;
    logic [MEM_BYTES*8-1:0] init_data = '0;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model_mem [MEM_BYTES];
    logic [7:0] image     [MEM_BYTES];

    data_mem_hs_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    data_mem_hs #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MEM_BYTES(MEM_BYTES),
        .LATENCY  (LATENCY)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .init_en  (init_en),
        .init_data(init_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_err(input logic [ADDR_W-1:0] a);
`ifdef DATA_MEM_CHECK_EN
        return ((a % NB) != 0) || (a >= MEM_BYTES);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int lane_addr(input logic [ADDR_W-1:0] a, input int k);
        return int'((a + 32'(k)) % MEM_BYTES);
    endfunction

    // Holds reset for two edges; starts and ends just after a falling edge.
    task automatic do_reset(input logic ie);
        @(negedge clk);
        reset         = 1'b1;
        init_en       = ie;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < MEM_BYTES; i++) model_mem[i] = ie ? image[i] : 8'h00;
        check_eq("rst_req_ready", bus.req_ready, 1);
        check_eq("rst_rsp_valid", bus.rsp_valid, 0);
        check_eq("rst_rsp_rdata", bus.rsp_rdata, 0);
        check_eq("rst_rsp_err",   bus.rsp_err,   0);
    endtask

    // One full access; entered and left just after a falling edge.
    task automatic access(input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input logic [NB-1:0] be,
                          input int stall, output logic [DATA_W-1:0] got);
        int n;
        logic [DATA_W-1:0] exp_d;
        logic e;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        bus.rsp_ready = 1'b0;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_ready_idle", bus.req_ready, 1);
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            check_eq("req_ready_busy", bus.req_ready, 0);
        end while (!bus.rsp_valid && n < 10);
        check_eq("latency", n, LATENCY);

        e     = exp_err(addr);
        exp_d = '0;
        if (!e) begin
            for (int k = 0; k < NB; k++) begin
                if (we) begin
                    if (be[k]) model_mem[lane_addr(addr, k)] = wdata[8*k +: 8];
                end else begin
                    exp_d[8*k +: 8] = model_mem[lane_addr(addr, k)];
                end
            end
        end
        got = bus.rsp_rdata;
        check_eq(we ? "wr_rdata" : "rd_rdata", got, exp_d);
        check_eq("rsp_err", bus.rsp_err, e);

        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check_eq("stall_valid", bus.rsp_valid, 1);
            check_eq("stall_rdata", bus.rsp_rdata, got);
            check_eq("stall_no_accept", bus.req_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check_eq("post_hs_valid", bus.rsp_valid, 0);
        check_eq("post_hs_ready", bus.req_ready, 1);
    endtask

    initial begin
        logic [DATA_W-1:0] got;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] exp_img;

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < MEM_BYTES; i++) begin
            image[i]              = 8'($urandom);
            init_data[8*i +: 8]   = image[i];
        end

        do_reset(1'b0);

        access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, got);
        access(1'b0, 32'h10, '0, 4'h0, 0, got);
        check_eq("t1_full_word", got, 32'hDEADBEEF);

        access(1'b1, 32'h10, 32'h11223344, 4'b0101, 0, got);
        access(1'b0, 32'h10, '0, 4'hF, 0, got);
        check_eq("t2_strobes", got, 32'hDE22BE44);

        access(1'b1, 32'h10, 32'hCAFEF00D, 4'h0, 1, got);
        access(1'b0, 32'h10, '0, 4'h0, 5, got);
        check_eq("be0_unchanged", got, 32'hDE22BE44);

        access(1'b1, 32'h1FC, 32'h8899AABB, 4'hF, 0, got);
        access(1'b1, 32'h0,   32'h44332211, 4'hF, 0, got);
        access(1'b0, 32'h1FE, '0, 4'hF, 0, got);
`ifdef DATA_MEM_CHECK_EN
        check_eq("t6_wrap_read", got, 32'h0);
`else
        check_eq("t6_wrap_read", got, 32'h22118899);
`endif

        // Write dropped by reset one cycle after accept; memory comes back from the image.
        do_reset(1'b1);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h40;
        bus.req_wdata = 32'h55AA55AA;
        bus.req_be    = 4'hF;
        @(posedge clk);
        do_reset(1'b1);
        access(1'b0, 32'h40, '0, 4'hF, 0, got);
        exp_img = {image[16'h43], image[16'h42], image[16'h41], image[16'h40]};
        check_eq("t5_preload", got, exp_img);

        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h40;
        bus.req_wdata = 32'h55AA55AA;
        bus.req_be    = 4'hF;
        @(posedge clk);
        do_reset(1'b0);
        access(1'b0, 32'h40, '0, 4'hF, 0, got);
        check_eq("t5_zero", got, 32'h0);

        do_reset(1'b1);
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 3))
                0, 1:    a = 32'($urandom_range(0, 127)) << 2;
                2:       a = 32'($urandom_range(0, MEM_BYTES - 1));
                default: a = $urandom;
            endcase
            access(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom),
                   $urandom_range(0, 2), got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
